// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared X-interface types: memory-arbiter origin tags, tracker entry and FSM states.
package cv32e40p_core_v_xif_pkg;

    localparam int unsigned XIF_ID_WIDTH = 4;

    typedef enum logic {
        ORIGIN_CORE = 1'b0,
        ORIGIN_X    = 1'b1
    } mem_origin_e;

    typedef struct packed {
        mem_origin_e             origin;
        logic [XIF_ID_WIDTH-1:0] id;
    } x_mem_outst_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_CORE = 2'd1,
        HOLD_X    = 2'd2
    } x_mem_arb_state_e;

endpackage

// File: rtl/cv32e40p_x_mem_outst_fifo.sv
// In-order tracker of outstanding OBI transactions; push and pop may coincide even when full.
module cv32e40p_x_mem_outst_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_en, pop_en;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_en = push_i & (~full_o | pop_i);
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_en && !pop_en)      cnt_q <= cnt_q + 1'b1;
            else if (!push_en && pop_en) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cv32e40p_x_mem_arb.sv
// Shares the data OBI port between the core LSU and the X-interface memory channel,
// routing each in-order response back to its originator.
module cv32e40p_x_mem_arb
    import cv32e40p_core_v_xif_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned X_ID_WIDTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  core_req_i,
    output logic                  core_gnt_o,
    input  logic [31:0]           core_addr_i,
    input  logic                  core_we_i,
    input  logic [3:0]            core_be_i,
    input  logic [31:0]           core_wdata_i,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    output logic                  core_err_o,
    input  logic                  x_mem_valid_i,
    output logic                  x_mem_ready_o,
    input  logic [31:0]           x_mem_addr_i,
    input  logic                  x_mem_we_i,
    input  logic [3:0]            x_mem_be_i,
    input  logic [31:0]           x_mem_wdata_i,
    input  logic [X_ID_WIDTH-1:0] x_mem_id_i,
    output logic                  x_mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0] x_mem_result_id_o,
    output logic [31:0]           x_mem_result_rdata_o,
    output logic                  x_mem_result_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [31:0]           data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i,
    output logic                  x_mem_busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    x_mem_arb_state_e state_q;
    mem_origin_e      last_winner_q, sel_c;
    logic [CNT_W-1:0] x_cnt_q;
    logic             req_c, push_c, pop_c, x_push_c, x_pop_c;
    logic             fifo_full, fifo_empty;
    x_mem_outst_t     push_entry, head;

    // Source selection: locked while holding, round-robin on contention in IDLE.
    always_comb begin
        sel_c = ORIGIN_CORE;
        req_c = 1'b0;
        case (state_q)
            HOLD_CORE: begin
                sel_c = ORIGIN_CORE;
                req_c = core_req_i;
            end
            HOLD_X: begin
                sel_c = ORIGIN_X;
                req_c = x_mem_valid_i;
            end
            default: begin
                if (core_req_i && x_mem_valid_i)
                    sel_c = (last_winner_q == ORIGIN_CORE) ? ORIGIN_X : ORIGIN_CORE;
                else if (x_mem_valid_i)
                    sel_c = ORIGIN_X;
                req_c = (core_req_i | x_mem_valid_i) & (~fifo_full | data_rvalid_i);
            end
        endcase
    end

    assign data_req_o    = req_c;
    assign data_addr_o   = (sel_c == ORIGIN_X) ? x_mem_addr_i  : core_addr_i;
    assign data_we_o     = (sel_c == ORIGIN_X) ? x_mem_we_i    : core_we_i;
    assign data_be_o     = (sel_c == ORIGIN_X) ? x_mem_be_i    : core_be_i;
    assign data_wdata_o  = (sel_c == ORIGIN_X) ? x_mem_wdata_i : core_wdata_i;
    assign core_gnt_o    = req_c & data_gnt_i & (sel_c == ORIGIN_CORE);
    assign x_mem_ready_o = req_c & data_gnt_i & (sel_c == ORIGIN_X);

    assign push_c            = req_c & data_gnt_i;
    assign pop_c             = data_rvalid_i & ~fifo_empty;
    assign x_push_c          = push_c & (sel_c == ORIGIN_X);
    assign x_pop_c           = pop_c & (head.origin == ORIGIN_X);
    assign push_entry.origin = sel_c;
    assign push_entry.id     = (sel_c == ORIGIN_X) ? XIF_ID_WIDTH'(x_mem_id_i) : '0;

    cv32e40p_x_mem_outst_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(x_mem_outst_t))
    ) u_outst_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_c),
        .data_i  (push_entry),
        .pop_i   (pop_c),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            last_winner_q <= ORIGIN_CORE;
            x_cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c && !data_gnt_i)
                        state_q <= (sel_c == ORIGIN_X) ? HOLD_X : HOLD_CORE;
                end
                HOLD_CORE, HOLD_X: begin
                    if (data_gnt_i || !req_c) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (push_c) last_winner_q <= sel_c;
            if (x_push_c && !x_pop_c)      x_cnt_q <= x_cnt_q + 1'b1;
            else if (!x_push_c && x_pop_c) x_cnt_q <= x_cnt_q - 1'b1;
        end
    end

    // Response routing by tracker head; data fields are zero when not valid.
    assign core_rvalid_o        = pop_c & (head.origin == ORIGIN_CORE);
    assign core_rdata_o         = core_rvalid_o ? data_rdata_i : '0;
    assign core_err_o           = core_rvalid_o & data_err_i;
    assign x_mem_result_valid_o = x_pop_c;
    assign x_mem_result_id_o    = x_pop_c ? X_ID_WIDTH'(head.id) : '0;
    assign x_mem_result_rdata_o = x_pop_c ? data_rdata_i : '0;
    assign x_mem_result_err_o   = x_pop_c & data_err_i;
    assign x_mem_busy_o         = (x_cnt_q != '0) | x_mem_valid_i;

    a_core_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD_CORE) |-> core_req_i);
    a_x_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD_X) |-> x_mem_valid_i);
    a_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> !fifo_empty)
        else $warning("data_rvalid_i with no outstanding transaction dropped");

endmodule

// File: tb/tb_cv32e40p_x_mem_arb.sv
// Directed bench for cv32e40p_x_mem_arb with hand-computed expectations.
module tb_cv32e40p_x_mem_arb;
    import cv32e40p_core_v_xif_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_gnt_o, core_we_i, core_rvalid_o, core_err_o;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic [3:0]  core_be_i;
    logic        x_mem_valid_i, x_mem_ready_o, x_mem_we_i;
    logic [31:0] x_mem_addr_i, x_mem_wdata_i, x_mem_result_rdata_o;
    logic [3:0]  x_mem_be_i, x_mem_id_i, x_mem_result_id_o;
    logic        x_mem_result_valid_o, x_mem_result_err_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        x_mem_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    cv32e40p_x_mem_arb #(.MAX_OUTSTANDING(2), .X_ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
        .core_we_i(core_we_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o), .x_mem_addr_i(x_mem_addr_i),
        .x_mem_we_i(x_mem_we_i), .x_mem_be_i(x_mem_be_i), .x_mem_wdata_i(x_mem_wdata_i),
        .x_mem_id_i(x_mem_id_i), .x_mem_result_valid_o(x_mem_result_valid_o),
        .x_mem_result_id_o(x_mem_result_id_o), .x_mem_result_rdata_o(x_mem_result_rdata_o),
        .x_mem_result_err_o(x_mem_result_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .x_mem_busy_o(x_mem_busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        core_req_i = 0; core_addr_i = 0; core_we_i = 0; core_be_i = 0; core_wdata_i = 0;
        x_mem_valid_i = 0; x_mem_addr_i = 0; x_mem_we_i = 0; x_mem_be_i = 0;
        x_mem_wdata_i = 0; x_mem_id_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0; data_err_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},    32'(data_req_o), 0);
        check({tag, "_cgnt"},   32'(core_gnt_o), 0);
        check({tag, "_xrdy"},   32'(x_mem_ready_o), 0);
        check({tag, "_crv"},    32'(core_rvalid_o), 0);
        check({tag, "_crdata"}, core_rdata_o, 0);
        check({tag, "_xrv"},    32'(x_mem_result_valid_o), 0);
        check({tag, "_busy"},   32'(x_mem_busy_o), 0);
    endtask

    task automatic do_reset();
        rst_ni = 0;
        clear_inputs();
        settle();
        rst_ni = 1;
        next_cycle();
    endtask

    initial begin
        rst_ni = 0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        check_quiet("reset");
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        check("reset_xcnt", 32'(dut.x_cnt_q), 0);
        rst_ni = 1;
        next_cycle();

        // Core-only read, response two cycles after grant
        core_req_i = 1; core_addr_i = 32'h0000_1000; core_be_i = 4'hF; data_gnt_i = 1;
        settle();
        check("t1_cgnt", 32'(core_gnt_o), 1);
        check("t1_addr", data_addr_o, 32'h0000_1000);
        check("t1_xrdy", 32'(x_mem_ready_o), 0);
        next_cycle();
        core_req_i = 0; data_gnt_i = 0;
        next_cycle();
        data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
        settle();
        check("t1_crv", 32'(core_rvalid_o), 1);
        check("t1_crdata", core_rdata_o, 32'hDEAD_BEEF);
        check("t1_xrv", 32'(x_mem_result_valid_o), 0);
        next_cycle();
        data_rvalid_i = 0; data_rdata_i = 0;

        // Contention from reset: X, core, X, core with in-order responses
        do_reset();
        core_req_i = 1; core_addr_i = 32'h0000_0100;
        x_mem_valid_i = 1; x_mem_addr_i = 32'h0000_2000; x_mem_id_i = 4'd3;
        data_gnt_i = 1;
        settle();
        check("t2_c0_xrdy", 32'(x_mem_ready_o), 1);
        check("t2_c0_cgnt", 32'(core_gnt_o), 0);
        check("t2_c0_addr", data_addr_o, 32'h0000_2000);
        next_cycle();
        x_mem_id_i = 4'd5; data_rvalid_i = 1; data_rdata_i = 32'h1111_1111;
        settle();
        check("t2_c1_cgnt", 32'(core_gnt_o), 1);
        check("t2_c1_xrdy", 32'(x_mem_ready_o), 0);
        check("t2_c1_xrv", 32'(x_mem_result_valid_o), 1);
        check("t2_c1_xid", 32'(x_mem_result_id_o), 3);
        check("t2_c1_xrdata", x_mem_result_rdata_o, 32'h1111_1111);
        next_cycle();
        data_rdata_i = 32'h2222_2222;
        settle();
        check("t2_c2_xrdy", 32'(x_mem_ready_o), 1);
        check("t2_c2_crv", 32'(core_rvalid_o), 1);
        check("t2_c2_crdata", core_rdata_o, 32'h2222_2222);
        check("t2_c2_xrv", 32'(x_mem_result_valid_o), 0);
        next_cycle();
        x_mem_valid_i = 0; data_rdata_i = 32'h3333_3333;
        settle();
        check("t2_c3_cgnt", 32'(core_gnt_o), 1);
        check("t2_c3_xrv", 32'(x_mem_result_valid_o), 1);
        check("t2_c3_xid", 32'(x_mem_result_id_o), 5);
        next_cycle();
        core_req_i = 0; data_gnt_i = 0; data_rdata_i = 32'h4444_4444;
        settle();
        check("t2_c4_crv", 32'(core_rvalid_o), 1);
        check("t2_c4_crdata", core_rdata_o, 32'h4444_4444);
        check("t2_c4_busy", 32'(x_mem_busy_o), 0);
        next_cycle();
        data_rvalid_i = 0; data_rdata_i = 0;

        // Grant stall on X while the core starts requesting
        x_mem_valid_i = 1; x_mem_addr_i = 32'h0000_3000; x_mem_id_i = 4'd7;
        settle();
        check("t3_c0_req", 32'(data_req_o), 1);
        check("t3_c0_addr", data_addr_o, 32'h0000_3000);
        check("t3_c0_xrdy", 32'(x_mem_ready_o), 0);
        next_cycle();
        core_req_i = 1; core_addr_i = 32'h0000_4000;
        for (int c = 1; c <= 2; c++) begin
            settle();
            check("t3_state", 32'(dut.state_q), 32'(HOLD_X));
            check("t3_addr", data_addr_o, 32'h0000_3000);
            check("t3_cgnt", 32'(core_gnt_o), 0);
            next_cycle();
        end
        data_gnt_i = 1;
        settle();
        check("t3_c3_xrdy", 32'(x_mem_ready_o), 1);
        check("t3_c3_cgnt", 32'(core_gnt_o), 0);
        check("t3_c3_addr", data_addr_o, 32'h0000_3000);
        next_cycle();
        x_mem_valid_i = 0;
        settle();
        check("t3_c4_cgnt", 32'(core_gnt_o), 1);
        check("t3_c4_addr", data_addr_o, 32'h0000_4000);
        next_cycle();

        // Full tracker blocks new requests; pop+push together keeps occupancy
        core_addr_i = 32'h0000_5000;
        settle();
        check("t4_full_cnt", 32'(dut.u_outst_fifo.cnt_q), 2);
        check("t4_full_req", 32'(data_req_o), 0);
        check("t4_full_cgnt", 32'(core_gnt_o), 0);
        check("t4_full_xrdy", 32'(x_mem_ready_o), 0);
        next_cycle();
        data_rvalid_i = 1; data_rdata_i = 32'h5555_5555;
        settle();
        check("t4_pp_req", 32'(data_req_o), 1);
        check("t4_pp_cgnt", 32'(core_gnt_o), 1);
        check("t4_pp_xrv", 32'(x_mem_result_valid_o), 1);
        check("t4_pp_xid", 32'(x_mem_result_id_o), 7);
        check("t4_pp_xrdata", x_mem_result_rdata_o, 32'h5555_5555);
        next_cycle();
        check("t4_pp_cnt", 32'(dut.u_outst_fifo.cnt_q), 2);
        core_req_i = 0; data_gnt_i = 0; data_rdata_i = 32'h6666_6666;
        settle();
        check("t4_d1_crdata", core_rdata_o, 32'h6666_6666);
        next_cycle();
        data_rdata_i = 32'h7777_7777;
        settle();
        check("t4_d2_crv", 32'(core_rvalid_o), 1);
        check("t4_d2_crdata", core_rdata_o, 32'h7777_7777);
        next_cycle();
        data_rvalid_i = 0; data_rdata_i = 0;
        settle();
        check("t4_empty_cnt", 32'(dut.u_outst_fifo.cnt_q), 0);

        // X write with bus error, then a spurious response
        x_mem_valid_i = 1; x_mem_we_i = 1; x_mem_be_i = 4'h3; x_mem_addr_i = 32'h0000_6000;
        x_mem_wdata_i = 32'hCAFE_0001; x_mem_id_i = 4'd9; data_gnt_i = 1;
        settle();
        check("t5_xrdy", 32'(x_mem_ready_o), 1);
        check("t5_we", 32'(data_we_o), 1);
        check("t5_be", 32'(data_be_o), 32'h3);
        check("t5_wdata", data_wdata_o, 32'hCAFE_0001);
        next_cycle();
        x_mem_valid_i = 0; x_mem_we_i = 0; data_gnt_i = 0;
        settle();
        check("t5_busy_out", 32'(x_mem_busy_o), 1);
        next_cycle();
        data_rvalid_i = 1; data_err_i = 1;
        settle();
        check("t5_xrv", 32'(x_mem_result_valid_o), 1);
        check("t5_xerr", 32'(x_mem_result_err_o), 1);
        check("t5_xid", 32'(x_mem_result_id_o), 9);
        check("t5_cerr", 32'(core_err_o), 0);
        next_cycle();
        data_err_i = 0; data_rdata_i = 32'h0BAD_0BAD;
        settle();
        check("t5_spur_crv", 32'(core_rvalid_o), 0);
        check("t5_spur_crdata", core_rdata_o, 0);
        check("t5_spur_xrv", 32'(x_mem_result_valid_o), 0);
        check("t5_spur_xrdata", x_mem_result_rdata_o, 0);
        check("t5_spur_busy", 32'(x_mem_busy_o), 0);
        next_cycle();
        data_rvalid_i = 0; data_rdata_i = 0;

        // Reset with two transactions outstanding
        core_req_i = 1; core_addr_i = 32'h0000_7000;
        x_mem_valid_i = 1; x_mem_addr_i = 32'h0000_8000; x_mem_id_i = 4'd2; data_gnt_i = 1;
        settle();
        check("t6_c0_cgnt", 32'(core_gnt_o), 1);
        next_cycle();
        core_req_i = 0;
        settle();
        check("t6_c1_xrdy", 32'(x_mem_ready_o), 1);
        next_cycle();
        x_mem_valid_i = 0; data_gnt_i = 0;
        settle();
        check("t6_pre_xcnt", 32'(dut.x_cnt_q), 1);
        check("t6_pre_cnt", 32'(dut.u_outst_fifo.cnt_q), 2);
        rst_ni = 0;
        clear_inputs();
        settle();
        check_quiet("t6_rst");
        check("t6_rst_xcnt", 32'(dut.x_cnt_q), 0);
        check("t6_rst_cnt", 32'(dut.u_outst_fifo.cnt_q), 0);
        rst_ni = 1;
        next_cycle();
        data_rvalid_i = 1; data_rdata_i = 32'h1234_5678;
        settle();
        check("t6_post_crv", 32'(core_rvalid_o), 0);
        check("t6_post_xrv", 32'(x_mem_result_valid_o), 0);
        next_cycle();
        data_rvalid_i = 0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_mem_arb.md
Name: cv32e40p_x_mem_arb

Overview:
- Arbitrates the single OBI data memory port between the core LSU and the X-interface memory channel (xmem requests from the coprocessor).
- Locks the port to one requester until grant, tracks outstanding transactions in order, and routes each response back to its originator: core LSU rvalid, or X-interface mem-result with the matching instruction ID.
- Sits between the LSU/X dispatcher and the data OBI master port.

Parameters:
- MAX_OUTSTANDING, 2, depth of the outstanding-transaction tracker; power of two, 1..8.
- X_ID_WIDTH, 4, width of the X-interface instruction ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  LSU request (OBI; address/control held stable until grant)
- core_gnt_o  out  1  LSU grant
- core_addr_i  in  32  LSU address
- core_we_i  in  1  LSU write enable
- core_be_i  in  4  LSU byte enables
- core_wdata_i  in  32  LSU write data
- core_rvalid_o  out  1  LSU response valid
- core_rdata_o  out  32  LSU read data
- core_err_o  out  1  LSU bus error
- x_mem_valid_i  in  1  X mem request valid (held until ready)
- x_mem_ready_o  out  1  X mem request accepted
- x_mem_addr_i  in  32  X mem address
- x_mem_we_i  in  1  X mem write enable
- x_mem_be_i  in  4  X mem byte enables
- x_mem_wdata_i  in  32  X mem write data
- x_mem_id_i  in  X_ID_WIDTH  X instruction ID
- x_mem_result_valid_o  out  1  X mem result valid
- x_mem_result_id_o  out  X_ID_WIDTH  ID of the returning X transaction
- x_mem_result_rdata_o  out  32  X read data
- x_mem_result_err_o  out  1  X bus error
- data_req_o  out  1  OBI request
- data_gnt_i  in  1  OBI grant
- data_addr_o  out  32  OBI address
- data_we_o  out  1  OBI write enable
- data_be_o  out  4  OBI byte enables
- data_wdata_o  out  32  OBI write data
- data_rvalid_i  in  1  OBI response valid
- data_rdata_i  in  32  OBI read data
- data_err_i  in  1  OBI error
- x_mem_busy_o  out  1  X transaction pending or outstanding; the dispatcher uses it to stall core memory instructions

Behaviour:
- Reset: FSM=IDLE; tracker empty; last_winner=CORE; x_cnt=0. All outputs 0.
- FSM states:
  - IDLE: may start a new request only if the tracker is not full, or a pop (data_rvalid_i) occurs in the same cycle.
  - HOLD_CORE / HOLD_X: a request has been presented without grant; the mux stays on that source and no re-arbitration occurs.
- Arbitration in IDLE:
  - Only one source requesting: that source wins.
  - Both requesting: round-robin; the winner is the source that is not last_winner.
  - last_winner updates only on a grant.
- Forwarding is combinational, zero cycles: data_req_o and payload come from the selected source. core_gnt_o = data_gnt_i & sel==CORE. x_mem_ready_o = data_gnt_i & sel==X.
- Transitions:
  - IDLE: data_req_o & ~data_gnt_i -> HOLD_<sel>.
  - HOLD_*: data_gnt_i -> IDLE.
  - A grant in IDLE stays in IDLE.
- Requester drop in HOLD: a requester deasserting in HOLD is a protocol violation; flag it by assertion. The RTL still returns to IDLE when the held req drops.
- Tracker push/pop:
  - Push {origin, id} on data_req_o & data_gnt_i; id = x_mem_id_i, or 0 for core.
  - Pop on data_rvalid_i.
  - Simultaneous push and pop is legal at any occupancy, including full.
- Response routing is by head origin, same cycle as data_rvalid_i:
  - CORE: core_rvalid_o=1, core_rdata_o/core_err_o = bus.
  - X: x_mem_result_valid_o=1, with id/rdata/err.
  - Data outputs are driven 0 when the corresponding valid is low.
- Spurious response: data_rvalid_i with an empty tracker is ignored (no valid out) and flagged by assertion.
- x_cnt counts X entries in the tracker: +1 on X push, -1 on X pop, unchanged on both. x_mem_busy_o = (x_cnt != 0) | x_mem_valid_i.
- Full tracker: data_req_o stays 0 in IDLE and both grants stay 0. An active HOLD is never aborted; the full check happens before entering HOLD.
- Reset mid-operation: all state clears. Responses arriving after reset for pre-reset requests are dropped as spurious.

Decomposition:
- Shared package cv32e40p_core_v_xif_pkg gains:
  - mem_origin_e {ORIGIN_CORE=1'b0, ORIGIN_X=1'b1}
  - x_mem_outst_t {mem_origin_e origin; logic [X_ID_WIDTH-1:0] id}
  - FSM typedef x_mem_arb_state_e {IDLE, HOLD_CORE, HOLD_X}
- Sub-module cv32e40p_x_mem_outst_fifo:
  - parameterised depth/width, in-order FIFO with full/empty.
  - push/pop in the same cycle allowed when full.

Test Plan:
- Core-only read: core_req_i=1, data_gnt_i=1 same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> core_gnt_o pulse at cycle 0, core_rvalid_o=1 with 0xDEADBEEF, x_mem_result_valid_o stays 0.
- Simultaneous requests, gnt always 1:
  - core and X both request for 4 cycles from reset -> grants alternate X, core, X, core.
  - Responses return in order: X results carry x_mem_id_i values 3 and 5 respectively.
- Grant stall: X request with data_gnt_i=0 for 3 cycles while core_req_i rises in cycle 1 -> FSM in HOLD_X, data_addr_o stays at the X address, core_gnt_o=0 until X is granted.
- Full tracker (MAX_OUTSTANDING=2): two grants without rvalid -> third request sees data_req_o=0. rvalid plus new request in the same cycle -> pop and push together, occupancy stays 2.
- Error and spurious response:
  - X write with data_err_i=1 -> x_mem_result_err_o=1, id matches.
  - Extra rvalid with an empty tracker -> no valid output; x_mem_busy_o=0 after the drain.
- Reset mid-operation: assert rst_ni=0 with 2 outstanding entries -> all outputs 0, x_cnt=0. A subsequent rvalid is ignored.
